// File: rtl/ysyx_22040210_csr_unit_if.sv
`default_nettype none
// ==================================================================
// ysyx_22040210_csr_unit_if : port bundle of the machine-mode CSR unit.
// Rev 1.0
// ==================================================================
interface ysyx_22040210_csr_unit_if #(
   parameter int XLEN = 64,
   parameter int NRD  = 2
);
   logic                 we_i;
   logic [11:0]          waddr_i;
   logic [XLEN-1:0]      wdata_i;
   logic [NRD-1:0]       re_i;
   logic [NRD*12-1:0]    raddr_i;
   logic [NRD*XLEN-1:0]  rdata_o;
   logic                 trap_i;
   logic [XLEN-1:0]      trap_pc_i;
   logic [XLEN-1:0]      trap_cause_i;
   logic                 mret_i;
   logic                 retire_i;
   logic                 irq_timer_i;
   logic [XLEN-1:0]      trap_vec_o;
   logic [XLEN-1:0]      mepc_o;
   logic                 irq_pend_o;

   modport master (
      output we_i, waddr_i, wdata_i, re_i, raddr_i,
      output trap_i, trap_pc_i, trap_cause_i, mret_i, retire_i, irq_timer_i,
      input  rdata_o, trap_vec_o, mepc_o, irq_pend_o
   );

   modport slave (
      input  we_i, waddr_i, wdata_i, re_i, raddr_i,
      input  trap_i, trap_pc_i, trap_cause_i, mret_i, retire_i, irq_timer_i,
      output rdata_o, trap_vec_o, mepc_o, irq_pend_o
   );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040210_csr_unit.sv
`default_nettype none
// ==================================================================
// ysyx_22040210_csr_unit : M-mode CSRs, bypassed read ports, trap/mret, timer irq.
// Optional cycle/instret counters: YSYX_22040210_CSR_COUNTERS_EN.   Rev 1.0
// ==================================================================
module ysyx_22040210_csr_unit #(
   parameter int          XLEN        = 64,
   parameter int          NRD         = 2,
   parameter logic [63:0] MSTATUS_RST = 64'ha00001800
) (
   input  logic clk,
   input  logic rst_n,
   ysyx_22040210_csr_unit_if.slave bus
);
   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MINSTRET = 12'hB02;

   localparam logic [XLEN-1:0] MST_RST   = MSTATUS_RST[XLEN-1:0];
   localparam logic [XLEN-1:0] MST_LIVE  = XLEN'(64'h1888);
   // Everything but MIE/MPIE is constant; MPP is hardwired to machine mode.
   localparam logic [XLEN-1:0] MST_FIXED = (MST_RST & ~MST_LIVE) | XLEN'(64'h1800);

   logic              mst_mie;
   logic              mst_mpie;
   logic              mie_mtie;
   logic              mip_mtip;
   logic              mtvec_vec;
   logic [XLEN-1:2]   mtvec_base;
   logic [XLEN-1:2]   mepc_q;
   logic [XLEN-1:0]   mcause_q;

   logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;

   assign wr_mstatus = bus.we_i && (bus.waddr_i == A_MSTATUS) && !bus.trap_i && !bus.mret_i;
   assign wr_mie     = bus.we_i && (bus.waddr_i == A_MIE);
   assign wr_mtvec   = bus.we_i && (bus.waddr_i == A_MTVEC);
   assign wr_mepc    = bus.we_i && (bus.waddr_i == A_MEPC) && !bus.trap_i;
   assign wr_mcause  = bus.we_i && (bus.waddr_i == A_MCAUSE) && !bus.trap_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mst_mie    <= MST_RST[3];
         mst_mpie   <= MST_RST[7];
         mie_mtie   <= 1'b0;
         mip_mtip   <= 1'b0;
         mtvec_vec  <= 1'b0;
         mtvec_base <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
      end else begin
         mip_mtip <= bus.irq_timer_i;

         if (bus.trap_i) begin
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
         end else if (bus.mret_i) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
         end else if (wr_mstatus) begin
            mst_mie  <= bus.wdata_i[3];
            mst_mpie <= bus.wdata_i[7];
         end

         if (bus.trap_i) begin
            mepc_q   <= bus.trap_pc_i[XLEN-1:2];
            mcause_q <= bus.trap_cause_i;
         end else begin
            if (wr_mepc)   mepc_q   <= bus.wdata_i[XLEN-1:2];
            if (wr_mcause) mcause_q <= bus.wdata_i;
         end

         if (wr_mie) mie_mtie <= bus.wdata_i[7];

         // Reserved vector modes (1x) collapse to direct mode.
         if (wr_mtvec) begin
            mtvec_base <= bus.wdata_i[XLEN-1:2];
            mtvec_vec  <= (bus.wdata_i[1:0] == 2'b01);
         end
      end
   end

`ifdef YSYX_22040210_CSR_COUNTERS_EN
   logic [XLEN-1:0] mcycle_q;
   logic [XLEN-1:0] minstret_q;
   logic            wr_mcycle, wr_minstret;

   assign wr_mcycle   = bus.we_i && (bus.waddr_i == A_MCYCLE);
   assign wr_minstret = bus.we_i && (bus.waddr_i == A_MINSTRET);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mcycle_q   <= wr_mcycle   ? bus.wdata_i : mcycle_q + XLEN'(1);
         minstret_q <= wr_minstret ? bus.wdata_i : minstret_q + XLEN'(bus.retire_i);
      end
   end
`else
   logic unused_retire;
   assign unused_retire = bus.retire_i;
`endif

   logic unused_pc_lsb;
   assign unused_pc_lsb = ^bus.trap_pc_i[1:0];

   function automatic logic writable(input logic [11:0] a);
      case (a)
         A_MSTATUS, A_MIE, A_MTVEC, A_MEPC, A_MCAUSE: writable = 1'b1;
`ifdef YSYX_22040210_CSR_COUNTERS_EN
         A_MCYCLE, A_MINSTRET:                        writable = 1'b1;
`endif
         default:                                     writable = 1'b0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] csr_value(input logic [11:0] a);
      case (a)
         A_MSTATUS:  csr_value = MST_FIXED | (XLEN'(mst_mie) << 3) | (XLEN'(mst_mpie) << 7);
         A_MIE:      csr_value = XLEN'(mie_mtie) << 7;
         A_MTVEC:    csr_value = {mtvec_base, 1'b0, mtvec_vec};
         A_MEPC:     csr_value = {mepc_q, 2'b00};
         A_MCAUSE:   csr_value = mcause_q;
         A_MIP:      csr_value = XLEN'(mip_mtip) << 7;
`ifdef YSYX_22040210_CSR_COUNTERS_EN
         A_MCYCLE:   csr_value = mcycle_q;
         A_MINSTRET: csr_value = minstret_q;
`endif
         default:    csr_value = '0;
      endcase
   endfunction

   logic [NRD*XLEN-1:0] rdata_flat;

   // Same-cycle bypass shows the WB write; trap/mret effects are only visible next cycle.
   always_comb begin
      rdata_flat = '0;
      for (int k = 0; k < NRD; k++) begin
         if (bus.re_i[k]) begin
            if (bus.we_i && (bus.waddr_i == bus.raddr_i[12*k +: 12]) && writable(bus.waddr_i))
               rdata_flat[k*XLEN +: XLEN] = bus.wdata_i;
            else
               rdata_flat[k*XLEN +: XLEN] = csr_value(bus.raddr_i[12*k +: 12]);
         end
      end
   end

   logic [XLEN-1:0] tvec_base;
   assign tvec_base = {mtvec_base, 2'b00};

   assign bus.rdata_o    = rdata_flat;
   assign bus.trap_vec_o = (mtvec_vec && bus.trap_cause_i[XLEN-1])
                         ? tvec_base + {bus.trap_cause_i[XLEN-3:0], 2'b00}
                         : tvec_base;
   assign bus.mepc_o     = {mepc_q, 2'b00};
   assign bus.irq_pend_o = mst_mie & mie_mtie & mip_mtip;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040210_csr_unit.sv
`default_nettype none
// ==================================================================
// tb_ysyx_22040210_csr_unit : directed scenarios plus random traffic vs. reference model.
// Rev 1.0
// ==================================================================
module tb_ysyx_22040210_csr_unit;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   ysyx_22040210_csr_unit_if #(.XLEN(64), .NRD(2)) bus();

   ysyx_22040210_csr_unit #(.XLEN(64), .NRD(2), .MSTATUS_RST(64'ha00001800)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: architectural value of each CSR as software reads it.
   logic [63:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mepc, m_mcause, m_mcycle, m_minstret;

   logic [11:0] addr_tab [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                  12'h344, 12'hB00, 12'hB02, 12'h301, 12'h7C0};

   task automatic model_reset();
      m_mstatus = 64'ha00001800;
      m_mie = 0; m_mip = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
      m_mcycle = 0; m_minstret = 0;
   endtask

   function automatic logic is_writable(input logic [11:0] a);
      if (a == 12'h300 || a == 12'h304 || a == 12'h305 || a == 12'h341 || a == 12'h342) return 1'b1;
`ifdef YSYX_22040210_CSR_COUNTERS_EN
      if (a == 12'hB00 || a == 12'hB02) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic [63:0] model_read(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h344: return m_mip;
`ifdef YSYX_22040210_CSR_COUNTERS_EN
         12'hB00: return m_mcycle;
         12'hB02: return m_minstret;
`endif
         default: return 64'h0;
      endcase
   endfunction

   function automatic logic [63:0] model_tvec(input logic [63:0] cause);
      logic [63:0] base;
      base = m_mtvec & ~64'h3;
      if (m_mtvec[1:0] == 2'b01 && cause[63]) return base + (cause << 2);
      return base;
   endfunction

   // Next architectural state from the rules, using the inputs present at this edge.
   task automatic model_clock();
      logic [63:0] n_mstatus, n_mie, n_mtvec, n_mepc, n_mcause, n_mcycle, n_minstret;
      if (!rst_n) begin
         model_reset();
         return;
      end
      n_mstatus = m_mstatus; n_mie = m_mie; n_mtvec = m_mtvec;
      n_mepc = m_mepc; n_mcause = m_mcause;
      n_mcycle = m_mcycle + 1; n_minstret = m_minstret + (bus.retire_i ? 1 : 0);
      if (bus.we_i) begin
         case (bus.waddr_i)
            12'h300: if (!bus.trap_i && !bus.mret_i)
                        n_mstatus = (m_mstatus & ~64'h1888) | (bus.wdata_i & 64'h88) | 64'h1800;
            12'h304: n_mie = bus.wdata_i & 64'h80;
            12'h305: n_mtvec = bus.wdata_i[1] ? (bus.wdata_i & ~64'h3) : (bus.wdata_i & ~64'h2);
            12'h341: if (!bus.trap_i) n_mepc = bus.wdata_i & ~64'h3;
            12'h342: if (!bus.trap_i) n_mcause = bus.wdata_i;
            12'hB00: n_mcycle = bus.wdata_i;
            12'hB02: n_minstret = bus.wdata_i;
            default: ;
         endcase
      end
      if (bus.trap_i) begin
         n_mepc    = bus.trap_pc_i & ~64'h3;
         n_mcause  = bus.trap_cause_i;
         n_mstatus = (m_mstatus & ~64'h88) | (m_mstatus[3] ? 64'h80 : 64'h0);
      end else if (bus.mret_i) begin
         n_mstatus = (m_mstatus & ~64'h88) | 64'h80 | (m_mstatus[7] ? 64'h8 : 64'h0);
      end
      m_mstatus = n_mstatus; m_mie = n_mie; m_mtvec = n_mtvec; m_mepc = n_mepc;
      m_mcause = n_mcause; m_mip = bus.irq_timer_i ? 64'h80 : 64'h0;
`ifdef YSYX_22040210_CSR_COUNTERS_EN
      m_mcycle = n_mcycle; m_minstret = n_minstret;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.we_i = 0; bus.waddr_i = 0; bus.wdata_i = 0; bus.re_i = 0; bus.raddr_i = 0;
      bus.trap_i = 0; bus.trap_pc_i = 0; bus.trap_cause_i = 0; bus.mret_i = 0;
      bus.retire_i = 0; bus.irq_timer_i = 0;
   endtask

   task automatic write_csr(input logic [11:0] a, input logic [63:0] d);
      bus.we_i = 1; bus.waddr_i = a; bus.wdata_i = d;
      step();
      bus.we_i = 0;
   endtask

   task automatic test_reset();
      logic [63:0] exp;
      write_csr(12'h305, 64'h80000001);
      write_csr(12'h304, 64'h80);
      bus.trap_i = 1; bus.trap_pc_i = 64'h1234; bus.trap_cause_i = 64'h3;
      #2 rst_n = 0;
      model_reset();
      #1;
      bus.trap_i = 0;
      for (int i = 0; i < 8; i++) begin
         bus.re_i = 2'b11;
         bus.raddr_i = {addr_tab[i], addr_tab[i]};
         #1;
         exp = (addr_tab[i] == 12'h300) ? 64'ha00001800 : 64'h0;
         n_vec++;
         if (bus.rdata_o[63:0] !== exp || bus.rdata_o[127:64] !== exp) begin
            n_err++;
            $display("FAIL reset_read %h: got %h/%h want %h", addr_tab[i], bus.rdata_o[63:0], bus.rdata_o[127:64], exp);
         end
      end
      n_vec++;
      if (bus.mepc_o !== 64'h0 || bus.irq_pend_o !== 1'b0 || bus.trap_vec_o !== 64'h0) begin
         n_err++;
         $display("FAIL reset_outputs: mepc %h pend %b tvec %h want 0/0/0", bus.mepc_o, bus.irq_pend_o, bus.trap_vec_o);
      end
      idle();
      step();
      rst_n = 1;
      step();
   endtask

   task automatic test_bypass();
      bus.we_i = 1; bus.waddr_i = 12'h305; bus.wdata_i = 64'h80000101;
      bus.re_i = 2'b10; bus.raddr_i = {12'h305, 12'h305};
      #1;
      n_vec++;
      if (bus.rdata_o[127:64] !== 64'h80000101) begin
         n_err++; $display("FAIL bypass_port1: got %h want %h", bus.rdata_o[127:64], 64'h80000101);
      end
      n_vec++;
      if (bus.rdata_o[63:0] !== 64'h0) begin
         n_err++; $display("FAIL bypass_port0_disabled: got %h want 0", bus.rdata_o[63:0]);
      end
      step();
      bus.we_i = 0; bus.trap_cause_i = 64'd5;
      #1;
      n_vec++;
      if (bus.rdata_o[127:64] !== 64'h80000101 || bus.trap_vec_o !== 64'h80000100) begin
         n_err++;
         $display("FAIL bypass_stored: got %h tvec %h want 80000101 tvec 80000100", bus.rdata_o[127:64], bus.trap_vec_o);
      end
      idle();
   endtask

   task automatic test_trap_mret();
      write_csr(12'h300, 64'h8);
      bus.re_i = 2'b11; bus.raddr_i = {12'h300, 12'h342};
      #1;
      n_vec++;
      if (bus.rdata_o[127:64] !== 64'ha00001808) begin
         n_err++; $display("FAIL mstatus_mie_set: got %h want %h", bus.rdata_o[127:64], 64'ha00001808);
      end
      bus.trap_i = 1; bus.trap_pc_i = 64'h80000046; bus.trap_cause_i = 64'd11;
      step();
      bus.trap_i = 0;
      #1;
      n_vec++;
      if (bus.mepc_o !== 64'h80000044 || bus.rdata_o[63:0] !== 64'd11 || bus.rdata_o[127:64] !== 64'ha00001880) begin
         n_err++;
         $display("FAIL trap_entry: mepc %h mcause %h mstatus %h want 80000044/b/a00001880",
                  bus.mepc_o, bus.rdata_o[63:0], bus.rdata_o[127:64]);
      end
      bus.mret_i = 1;
      step();
      bus.mret_i = 0;
      #1;
      n_vec++;
      if (bus.rdata_o[127:64] !== 64'ha00001888) begin
         n_err++; $display("FAIL mret: mstatus %h want %h", bus.rdata_o[127:64], 64'ha00001888);
      end
      idle();
   endtask

   task automatic test_vectored();
      write_csr(12'h305, 64'h80000001);
      bus.trap_i = 1; bus.trap_pc_i = 64'h80000100; bus.trap_cause_i = 64'h8000000000000007;
      bus.we_i = 1; bus.waddr_i = 12'h341; bus.wdata_i = 64'h12345678;
      #1;
      n_vec++;
      if (bus.trap_vec_o !== 64'h8000001c) begin
         n_err++; $display("FAIL vectored_target: got %h want %h", bus.trap_vec_o, 64'h8000001c);
      end
      step();
      idle();
      #1;
      n_vec++;
      if (bus.mepc_o !== 64'h80000100) begin
         n_err++; $display("FAIL trap_beats_write: mepc %h want %h", bus.mepc_o, 64'h80000100);
      end
   endtask

   task automatic test_timer();
      write_csr(12'h300, 64'h8);
      write_csr(12'h304, 64'h80);
      bus.irq_timer_i = 1;
      #1;
      n_vec++;
      if (bus.irq_pend_o !== 1'b0) begin
         n_err++; $display("FAIL timer_latency: pend %b want 0", bus.irq_pend_o);
      end
      step();
      bus.re_i = 2'b01; bus.raddr_i = {12'h0, 12'h344};
      #1;
      n_vec++;
      if (bus.irq_pend_o !== 1'b1 || bus.rdata_o[63:0] !== 64'h80) begin
         n_err++; $display("FAIL timer_pending: pend %b mip %h want 1/80", bus.irq_pend_o, bus.rdata_o[63:0]);
      end
      write_csr(12'h300, 64'h0);
      #1;
      n_vec++;
      if (bus.irq_pend_o !== 1'b0) begin
         n_err++; $display("FAIL timer_masked: pend %b want 0", bus.irq_pend_o);
      end
      idle();
   endtask

   task automatic test_counters();
      logic [63:0] exp_a, exp_b, exp_c;
`ifdef YSYX_22040210_CSR_COUNTERS_EN
      exp_a = 64'hFFFFFFFFFFFFFFFF; exp_b = 64'h0; exp_c = 64'd3;
`else
      exp_a = 64'h0; exp_b = 64'h0; exp_c = 64'h0;
`endif
      write_csr(12'hB02, 64'h0);
      write_csr(12'hB00, 64'hFFFFFFFFFFFFFFFF);
      bus.re_i = 2'b01; bus.raddr_i = {12'hB02, 12'hB00};
      #1;
      n_vec++;
      if (bus.rdata_o[63:0] !== exp_a) begin
         n_err++; $display("FAIL mcycle_load: got %h want %h", bus.rdata_o[63:0], exp_a);
      end
      step();
      #1;
      n_vec++;
      if (bus.rdata_o[63:0] !== exp_b) begin
         n_err++; $display("FAIL mcycle_wrap: got %h want %h", bus.rdata_o[63:0], exp_b);
      end
      for (int i = 0; i < 3; i++) begin
         bus.retire_i = 1; step();
         bus.retire_i = 0; step();
      end
      bus.re_i = 2'b10;
      #1;
      n_vec++;
      if (bus.rdata_o[127:64] !== exp_c) begin
         n_err++; $display("FAIL minstret_count: got %h want %h", bus.rdata_o[127:64], exp_c);
      end
      idle();
   endtask

   task automatic test_random();
      logic [63:0] exp;
      for (int c = 0; c < 400; c++) begin
         bus.we_i         = ($urandom_range(0, 1) == 1);
         bus.waddr_i      = addr_tab[$urandom_range(0, 9)];
         bus.wdata_i      = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) bus.wdata_i[63:8] = 0;
         bus.re_i         = 2'($urandom_range(0, 3));
         bus.raddr_i      = {addr_tab[$urandom_range(0, 9)], addr_tab[$urandom_range(0, 9)]};
         bus.trap_i       = ($urandom_range(0, 9) == 0);
         bus.trap_pc_i    = {$urandom, $urandom};
         bus.trap_cause_i = {$urandom_range(0, 1) == 1, 55'h0, 8'($urandom_range(0, 255))};
         bus.mret_i       = ($urandom_range(0, 7) == 0);
         bus.retire_i     = ($urandom_range(0, 1) == 1);
         bus.irq_timer_i  = ($urandom_range(0, 2) == 0);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (!bus.re_i[k]) exp = 0;
            else if (bus.we_i && bus.waddr_i == bus.raddr_i[12*k +: 12] && is_writable(bus.waddr_i)) exp = bus.wdata_i;
            else exp = model_read(bus.raddr_i[12*k +: 12]);
            n_vec++;
            if (bus.rdata_o[64*k +: 64] !== exp) begin
               n_err++;
               $display("FAIL rand_read c%0d p%0d addr %h: got %h want %h", c, k, bus.raddr_i[12*k +: 12], bus.rdata_o[64*k +: 64], exp);
            end
         end
         n_vec++;
         if (bus.trap_vec_o !== model_tvec(bus.trap_cause_i)) begin
            n_err++; $display("FAIL rand_tvec c%0d: got %h want %h", c, bus.trap_vec_o, model_tvec(bus.trap_cause_i));
         end
         n_vec++;
         if (bus.mepc_o !== m_mepc || bus.irq_pend_o !== (m_mstatus[3] & m_mie[7] & m_mip[7])) begin
            n_err++;
            $display("FAIL rand_state c%0d: mepc %h pend %b want %h %b", c, bus.mepc_o, bus.irq_pend_o, m_mepc,
                     m_mstatus[3] & m_mie[7] & m_mip[7]);
         end
         step();
      end
      idle();
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 0;
      idle();
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1;
      step();
      test_reset();
      test_bypass();
      test_trap_mret();
      test_vectored();
      test_timer();
      test_counters();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
